seg_display_driver: RTL

Board-level debug output stage directly downstream of the pipelined CPU top. It consumes the CPU's current PC and register-file write-back value, snapshots their low 16 bits once per display frame, and time-multiplexes them onto an 8-digit common-anode seven-segment display as hex. The left four digits show the PC and the right four show the write-back data. All outputs are registered; the block replaces the external display driver path on the FPGA build.

---
 rtl/seg_display_driver.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_display_driver.sv
// Purpose: snapshots low 16 bits of CPU PC / write-back once per frame and scans them as hex on an 8-digit common-anode display.
// Latency: registered outputs; en_out/out7 reflect digit index and snapshot one cycle after they change.
// Backpressure: none; free-running scan, hold=1 freezes the snapshot at frame boundaries only.
module seg_display_driver #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [31:0] pc_value,
    input  logic [31:0] write_data,
    input  logic        hold,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      pc_snap_q, pc_snap_d;
    logic [15:0]      wd_snap_q, wd_snap_d;
    logic [6:0]       out7_q, out7_d;
    logic [7:0]       en_out_q, en_out_d;
    logic [3:0]       nibble;
    logic             cnt_wrap;

    // Upper halves of the CPU buses are deliberately not displayed.
    logic unused_upper;
    assign unused_upper = ^{pc_value[31:16], write_data[31:16]};

    // Active-low {g,f,e,d,c,b,a} hex font.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: dwell counter, digit advance, frame-boundary snapshot, output decode.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        digit_idx_d   = digit_idx_q;
        pc_snap_d     = pc_snap_q;
        wd_snap_d     = wd_snap_q;
        cnt_wrap      = (refresh_cnt_q == CNT_MAX);

        if (cnt_wrap) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 3'd1;
            // Load only when leaving digit 7 so a frame never mixes old and new values.
            if (digit_idx_q == 3'd7 && !hold) begin
                pc_snap_d = pc_value[15:0];
                wd_snap_d = write_data[15:0];
            end
        end

        case (digit_idx_q)
            3'd0:    nibble = wd_snap_q[3:0];
            3'd1:    nibble = wd_snap_q[7:4];
            3'd2:    nibble = wd_snap_q[11:8];
            3'd3:    nibble = wd_snap_q[15:12];
            3'd4:    nibble = pc_snap_q[3:0];
            3'd5:    nibble = pc_snap_q[7:4];
            3'd6:    nibble = pc_snap_q[11:8];
            default: nibble = pc_snap_q[15:12];
        endcase

        en_out_d = ~(8'b1 << digit_idx_q);
        out7_d   = hex7seg(nibble);
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 3'd0;
            pc_snap_q     <= 16'h0;
            wd_snap_q     <= 16'h0;
            out7_q        <= 7'h7F;
            en_out_q      <= 8'hFF;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pc_snap_q     <= pc_snap_d;
            wd_snap_q     <= wd_snap_d;
            out7_q        <= out7_d;
            en_out_q      <= en_out_d;
        end
    end

    assign out7   = out7_q;
    assign en_out = en_out_q;

endmodule
